// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier with HI/LO result registers.
// Performs one add-and-shift step per clock while the MUL code is held, and serves MFHI/MFLO reads.
module shift_add_multiplier #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CNT_W   = 6,
  parameter logic [5:0]  OP_MUL  = 6'b011011,
  parameter logic [5:0]  OP_MFHI = 6'b010000,
  parameter logic [5:0]  OP_MFLO = 6'b010010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [PW-1:0]      prod_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   dataout_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH:0]     sum_d;
  logic [PW-1:0]      prod_d;
  logic               is_mul;
  logic               last_iter;

  // Upper-half add keeps its carry, which becomes the new MSB after the right shift.
  always_comb begin
    sum_d     = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d    = {sum_d, prod_q[WIDTH-1:1]};
    is_mul    = (Signal == OP_MUL);
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dataout_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Reads see the HI/LO contents from before this edge.
      if (Signal == OP_MFHI) begin
        dataout_q <= hi_q;
      end else if (Signal == OP_MFLO) begin
        dataout_q <= lo_q;
      end

      case (state_q)
        IDLE: begin
          if (is_mul) begin
            mcand_q <= dataA;
            prod_q  <= {{WIDTH{1'b0}}, dataB};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (is_mul) begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (last_iter) begin
              hi_q    <= prod_d[PW-1:WIDTH];
              lo_q    <= prod_d[WIDTH-1:0];
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= HOLD;
            end
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        HOLD: begin
          // A held MUL code must be released before another run can start.
          if (!is_mul) begin
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dataOut = dataout_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier.
module tb_shift_add_multiplier;

  localparam int unsigned WIDTH = 32;
  localparam logic [5:0] OP_MUL  = 6'b011011;
  localparam logic [5:0] OP_MFHI = 6'b010000;
  localparam logic [5:0] OP_MFLO = 6'b010010;
  localparam logic [5:0] OP_ADD  = 6'b100000;

  logic             clk;
  logic             reset;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] dataOut;
  logic             busy;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done;

  shift_add_multiplier #(
    .WIDTH(WIDTH), .CNT_W(6), .OP_MUL(OP_MUL), .OP_MFHI(OP_MFHI), .OP_MFLO(OP_MFLO)
  ) dut (
    .clk(clk), .reset(reset), .Signal(Signal), .dataA(dataA), .dataB(dataB),
    .dataOut(dataOut), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1ns after it and inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input logic [5:0] code, input string tag, input logic [WIDTH-1:0] exp);
    Signal = code;
    tick();
    check(tag, 64'(dataOut), 64'(exp));
  endtask

  // Full run: start edge, 31 silent iterations, done on the 32nd, then release MUL.
  task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
    Signal = OP_MUL;
    dataA  = a;
    dataB  = b;
    tick();
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    n_done = 0;
    for (int i = 1; i < 32; i++) begin
      tick();
      if (done) n_done++;
    end
    check({tag, "_no_early_done"}, 64'(n_done), 64'd0);
    check({tag, "_busy_e31"}, 64'(busy), 64'd1);
    tick();
    check({tag, "_done_e32"}, 64'(done), 64'd1);
    check({tag, "_busy_e32"}, 64'(busy), 64'd0);
    Signal = OP_ADD;
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    reset  = 1'b1;
    Signal = OP_ADD;
    dataA  = '0;
    dataB  = '0;

    // 1: reset state
    tick();
    tick();
    reset = 1'b0;
    check("rst_dataout", 64'(dataOut), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    read_chk(OP_MFHI, "rst_mfhi", 32'd0);
    read_chk(OP_MFLO, "rst_mflo", 32'd0);

    // 2: small product
    run_mul(32'd7, 32'd6, "m7x6");
    read_chk(OP_MFLO, "m7x6_lo", 32'd42);
    read_chk(OP_MFHI, "m7x6_hi", 32'd0);

    // 3: all-ones operands exercise the carry into the MSB
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mmax");
    read_chk(OP_MFHI, "mmax_hi", 32'hFFFF_FFFE);
    read_chk(OP_MFLO, "mmax_lo", 32'h0000_0001);

    // 4: abort at edge 10 leaves HI/LO untouched
    Signal = OP_MUL;
    dataA  = 32'd5;
    dataB  = 32'd3;
    for (int i = 0; i < 10; i++) tick();
    check("abort_busy_before", 64'(busy), 64'd1);
    Signal = OP_ADD;
    tick();
    check("abort_busy", 64'(busy), 64'd0);
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);
    read_chk(OP_MFHI, "abort_hi", 32'hFFFF_FFFE);
    read_chk(OP_MFLO, "abort_lo", 32'h0000_0001);

    // 5: MUL held 40 cycles yields exactly one run, then a fresh run after release
    Signal = OP_MUL;
    dataA  = 32'd9;
    dataB  = 32'd11;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) n_done++;
    end
    check("hold_one_done", 64'(n_done), 64'd1);
    check("hold_no_restart", 64'(busy), 64'd0);
    Signal = OP_ADD;
    tick();
    read_chk(OP_MFLO, "hold_lo", 32'd99);
    run_mul(32'd2, 32'd10, "rerun");
    read_chk(OP_MFLO, "rerun_lo", 32'd20);

    // 6: reset mid-run clears everything
    Signal = OP_MUL;
    dataA  = 32'd100;
    dataB  = 32'd100;
    for (int i = 0; i < 15; i++) tick();
    check("mid_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    Signal = OP_ADD;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_dataout", 64'(dataOut), 64'd0);
    tick();
    read_chk(OP_MFHI, "mid_rst_hi", 32'd0);
    read_chk(OP_MFLO, "mid_rst_lo", 32'd0);
    run_mul(32'd3, 32'd4, "m3x4");
    read_chk(OP_MFLO, "m3x4_lo", 32'd12);
    read_chk(OP_MFHI, "m3x4_hi", 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
